// File: rtl/recovery_cmd_receiver.sv
// Recovery command receiver: parses CMD, LEN_L, LEN_H, payload, PEC frames from
// an RX byte stream, forwards payload bytes with zero latency, checks a CRC-8
// PEC and reports each frame (or read request / abort / timeout) on a
// command handshake.
//
// Handshakes: every interface uses valid/ready. A transfer happens on a rising
// clk_i edge where valid and ready are both 1; valid does not wait for ready,
// and a source holds its data stable while valid is high and ready is low.
// pl_valid_o/pl_data_o are a combinational view of rx_valid_i/rx_data_i, and
// rx_ready_o follows pl_ready_i in the payload phase.
module recovery_cmd_receiver #(
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned MaxLen        = 256,
  parameter int unsigned TimeoutCycles = 0,
  parameter logic [7:0]  PecPoly       = 8'h07
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                bus_start_i,
  input  logic                bus_stop_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  input  logic [7:0]          rx_data_i,
  output logic                pl_valid_o,
  input  logic                pl_ready_i,
  output logic [7:0]          pl_data_o,
  output logic                pl_last_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic                cmd_is_rd_o,
  output logic [7:0]          cmd_cmd_o,
  output logic [LenWidth-1:0] cmd_len_o,
  output logic [2:0]          cmd_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_CMD   = 3'd1,
    ST_RX_LEN_L = 3'd2,
    ST_RX_LEN_H = 3'd3,
    ST_RX_DATA  = 3'd4,
    ST_RX_PEC   = 3'd5,
    ST_REPORT   = 3'd6
  } state_e;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_PEC     = 3'd1;
  localparam logic [2:0] ERR_OVERLEN = 3'd2;
  localparam logic [2:0] ERR_ABORT   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // One CRC-8 step over a whole byte, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ PecPoly) : (c << 1);
    end
    return c;
  endfunction

  // FSM state (state_q is the observable state for checkers)
  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  crc_q, crc_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] timer_q, timer_d;
  // Frame being received
  logic [7:0]  fcmd_q, fcmd_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic        ovl_q, ovl_d;
  // Report held for the command handshake
  logic [7:0]  rep_cmd_q, rep_cmd_d;
  logic [15:0] rep_len_q, rep_len_d;
  logic [2:0]  rep_err_q, rep_err_d;
  logic        rep_rd_q, rep_rd_d;

  logic        accept;
  logic        counting;
  logic        to_report;
  logic        is_rd;
  logic [2:0]  err_code;
  logic [7:0]  crc_upd;
  logic [15:0] wire_len;
  logic        timeout_hit;

  assign pl_data_o   = rx_data_i;
  assign cmd_valid_o = (state_q == ST_REPORT);
  assign cmd_is_rd_o = rep_rd_q;
  assign cmd_cmd_o   = rep_cmd_q;
  assign cmd_len_o   = LenWidth'(rep_len_q);
  assign cmd_err_o   = rep_err_q;

  // Next-state, byte handshake, payload pass-through and report capture
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    crc_d       = crc_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    fcmd_d      = fcmd_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    rep_cmd_d   = rep_cmd_q;
    rep_len_d   = rep_len_q;
    rep_err_d   = rep_err_q;
    rep_rd_d    = rep_rd_q;
    rx_ready_o  = 1'b0;
    pl_valid_o  = 1'b0;
    pl_last_o   = 1'b0;
    accept      = 1'b0;
    counting    = 1'b0;
    to_report   = 1'b0;
    is_rd       = 1'b0;
    err_code    = ERR_OK;
    crc_upd     = crc8_byte(crc_q, rx_data_i);
    wire_len    = {rx_data_i, len_lo_q};
    timeout_hit = (TimeoutCycles != 0) && (timer_q == TimeoutCycles - 32'd1);

    case (state_q)
      ST_IDLE: begin
        if (bus_start_i || pend_q) begin
          state_d  = ST_RX_CMD;
          pend_d   = 1'b0;
          crc_d    = 8'h00;
          rem_d    = 16'h0000;
          fcmd_d   = 8'h00;
          len_lo_d = 8'h00;
          len_d    = 16'h0000;
          ovl_d    = 1'b0;
        end
      end
      ST_RX_CMD: begin
        rx_ready_o = 1'b1;
        accept     = rx_valid_i;
        if (accept) begin
          fcmd_d = rx_data_i;
          crc_d  = crc_upd;
          if (bus_stop_i) begin
            to_report = 1'b1;
            err_code  = ERR_ABORT;
          end else begin
            state_d = ST_RX_LEN_L;
          end
        end else if (bus_stop_i) begin
          // STOP before any byte: nothing to report
          state_d = ST_IDLE;
        end
      end
      ST_RX_LEN_L: begin
        counting   = 1'b1;
        rx_ready_o = !bus_start_i;
        accept     = rx_valid_i && !bus_start_i;
        if (bus_start_i) begin
          // Repeated START right after CMD is a read request
          to_report = 1'b1;
          is_rd     = 1'b1;
        end else if (accept) begin
          len_lo_d = rx_data_i;
          crc_d    = crc_upd;
          state_d  = ST_RX_LEN_H;
        end
      end
      ST_RX_LEN_H: begin
        counting   = 1'b1;
        rx_ready_o = 1'b1;
        accept     = rx_valid_i;
        if (accept) begin
          len_d   = wire_len;
          rem_d   = wire_len;
          ovl_d   = 32'(wire_len) > MaxLen;
          crc_d   = crc_upd;
          state_d = (wire_len != 16'h0000) ? ST_RX_DATA : ST_RX_PEC;
        end
      end
      ST_RX_DATA: begin
        counting   = 1'b1;
        rx_ready_o = ovl_q | pl_ready_i;
        pl_valid_o = rx_valid_i & !ovl_q;
        pl_last_o  = !ovl_q && (rem_q == 16'd1);
        accept     = rx_valid_i & rx_ready_o;
        if (accept) begin
          crc_d = crc_upd;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_RX_PEC;
        end
      end
      ST_RX_PEC: begin
        counting   = 1'b1;
        rx_ready_o = 1'b1;
        accept     = rx_valid_i;
        if (accept) begin
          // A STOP in the same cycle as the PEC byte still completes the frame
          to_report = 1'b1;
          if (ovl_q)                   err_code = ERR_OVERLEN;
          else if (rx_data_i != crc_q) err_code = ERR_PEC;
          else                         err_code = ERR_OK;
        end
      end
      ST_REPORT: begin
        if (cmd_ready_i) state_d = ST_IDLE;
        if (bus_start_i) pend_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Mid-frame abort outranks timeout; a just-accepted byte is already folded in
    if (counting && !to_report) begin
      if (bus_stop_i) begin
        to_report = 1'b1;
        err_code  = ERR_ABORT;
      end else if (!accept && timeout_hit) begin
        to_report = 1'b1;
        err_code  = ERR_TIMEOUT;
      end
    end

    if (to_report) begin
      state_d   = ST_REPORT;
      rep_cmd_d = fcmd_d;
      rep_len_d = is_rd ? 16'h0000 : len_d;
      rep_err_d = err_code;
      rep_rd_d  = is_rd;
    end

    // Disable drops back to Idle but keeps the last report contents
    if (!enable_i) begin
      state_d   = ST_IDLE;
      pend_d    = 1'b0;
      rep_cmd_d = rep_cmd_q;
      rep_len_d = rep_len_q;
      rep_err_d = rep_err_q;
      rep_rd_d  = rep_rd_q;
    end

    if (accept || (state_d != state_q)) timer_d = 32'd0;
    else if (counting)                  timer_d = timer_q + 32'd1;
    else                                timer_d = 32'd0;
  end

  // State and data registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      crc_q     <= 8'h00;
      rem_q     <= 16'h0000;
      timer_q   <= 32'd0;
      fcmd_q    <= 8'h00;
      len_lo_q  <= 8'h00;
      len_q     <= 16'h0000;
      ovl_q     <= 1'b0;
      rep_cmd_q <= 8'h00;
      rep_len_q <= 16'h0000;
      rep_err_q <= 3'd0;
      rep_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      crc_q     <= crc_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      fcmd_q    <= fcmd_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      rep_cmd_q <= rep_cmd_d;
      rep_len_q <= rep_len_d;
      rep_err_q <= rep_err_d;
      rep_rd_q  <= rep_rd_d;
    end
  end

endmodule

// File: doc/recovery_cmd_receiver.md
Name: recovery_cmd_receiver

Overview:
Parametrised successor to the TTI recovery command receiver. Parses recovery frames from an RX byte stream: CMD, LEN_L, LEN_H, payload, PEC. Computes CRC-8 PEC internally, forwards payload bytes to a downstream sink with valid/ready, and reports each frame on a command handshake with an error code. Adds an overlength check, idle-timeout and abort detection, and a cmd_ready_i handshake in place of a done pulse.

Parameters:
LenWidth, 16, width of cmd_len_o; values above 16 are zero-extended from the 16-bit wire length.
MaxLen, 256, largest accepted payload length; longer frames are consumed but flagged.
TimeoutCycles, 0, idle clocks allowed between bytes inside a frame; 0 disables the timeout.
PecPoly, 8'h07, CRC-8 polynomial; initial value 8'h00, MSB-first.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  block enable; low forces Idle synchronously
bus_start_i  in  1  START or repeated START pulse
bus_stop_i  in  1  STOP pulse
rx_valid_i  in  1  RX byte valid
rx_ready_o  out  1  RX byte ready
rx_data_i  in  8  RX byte
pl_valid_o  out  1  payload byte valid
pl_ready_i  in  1  payload sink ready
pl_data_o  out  8  payload byte
pl_last_o  out  1  final payload byte of the frame
cmd_valid_o  out  1  frame report valid
cmd_ready_i  in  1  frame report accepted
cmd_is_rd_o  out  1  read request (CMD followed by repeated START)
cmd_cmd_o  out  8  command byte
cmd_len_o  out  LenWidth  received length field
cmd_err_o  out  3  0 ok, 1 PEC mismatch, 2 overlength, 3 aborted, 4 timeout

Behaviour:
- Reset values: rx_ready_o, pl_valid_o, pl_last_o, cmd_valid_o and cmd_is_rd_o are 0. cmd_cmd_o, cmd_len_o, cmd_err_o, the CRC, the counters and the pending-start flag are 0.
- States: Idle, RxCmd, RxLenL, RxLenH, RxData, RxPec, Report.
- Transitions:
  - Idle -> RxCmd on bus_start_i or pending-start.
  - RxCmd/RxLenL/RxLenH/RxPec each advance on one accepted byte (rx_valid_i & rx_ready_o).
  - RxLenH -> RxData if len != 0, else -> RxPec.
  - RxData -> RxPec on acceptance of the last payload byte.
  - RxPec -> Report.
  - Report -> Idle on cmd_valid_o & cmd_ready_i.
- rx_ready_o:
  - 1 in RxCmd, RxLenL, RxLenH and RxPec.
  - In RxData: equals pl_ready_i (combinational pass-through) when not overlength; 1 when overlength.
  - 0 in Idle and Report.
- Payload path: pl_valid_o = rx_valid_i in RxData when not overlength; pl_data_o = rx_data_i; zero latency. pl_last_o = 1 when remaining count == 1.
- Remaining counter: loaded from {LEN_H, LEN_L}; decremented on each accepted payload byte. Overlength is flagged at the LEN_H accept when the length exceeds MaxLen.
- CRC: updated on every accepted byte of CMD, LEN_L, LEN_H and payload, including discarded payload. The PEC byte is compared against the running CRC.
- Read request: bus_start_i while in RxLenL (after CMD) -> Report with cmd_is_rd_o = 1, len = 0, err = 0. No PEC is checked.
- Error priority: aborted > timeout > overlength > PEC.
- bus_stop_i:
  - In Idle: ignored.
  - In RxCmd before any byte: -> Idle with no report.
  - Elsewhere mid-frame (RxLenL..RxPec): -> Report with err = 3.
- Simultaneous byte accept and bus_stop_i: the byte is processed first. If that byte was the PEC, the frame completes normally; otherwise it is reported as aborted.
- Timeout:
  - Counter clears on each accepted byte and on state entry.
  - Counts only in RxCmd (after the first byte), RxLenL, RxLenH, RxData and RxPec.
  - Reaching TimeoutCycles -> Report with err = 4.
- Report: cmd_* are registered and held stable while cmd_valid_o = 1, until the handshake completes.
- Pending start: bus_start_i during Report sets the pending-start flag, so Idle re-enters RxCmd on the next cycle. The flag is cleared when RxCmd is entered.
- enable_i low: next clock -> Idle; cmd_valid_o = 0; pending-start flag cleared; held data is retained.
- rst_i asserted mid-frame: all state returns to reset values immediately, with no report.

Test Plan:
- Zero-length write: start, bytes 26 00 00 3E -> one report: cmd 0x26, len 0, err 0, is_rd 0; no pl_valid_o.
- Four-byte write with pl_ready_i toggling every cycle: all 4 bytes appear in order, pl_last_o on the 4th; correct PEC -> err 0. Repeat with PEC^0x01 -> err 1.
- Length 0x0101 (257) with MaxLen = 256: all 257 payload bytes are consumed and pl_valid_o never rises -> err 2.
- Read: start, CMD 0x22, repeated start -> cmd_is_rd_o = 1, len 0, err 0. A STOP after LEN_L -> err 3.
- TimeoutCycles = 8: stall 8 cycles after LEN_L -> err 4. Hold cmd_ready_i low for 5 cycles: report stays stable; a start during the hold leads to RxCmd the cycle after the handshake.
- enable_i low mid-payload -> Idle next clock with no report. rst_i pulse mid-frame -> all outputs 0 asynchronously.
